// File: rtl/fifo_word_packer_if.sv
// Bundles the fifo-read side, the flush request and the packed output beat.
interface fifo_word_packer_if #(
    parameter int unsigned DWIDTH = 4,
    parameter int unsigned PACK   = 4
);
    localparam int unsigned CW = $clog2(PACK + 1);

    logic [DWIDTH-1:0]      fifo_q_i;
    logic                   fifo_empty_i;
    logic                   fifo_rdreq_o;
    logic                   flush_i;
    logic [DWIDTH*PACK-1:0] data_o;
    logic [CW-1:0]          words_o;
    logic                   valid_o;
    logic                   ready_i;

    // Packer side
    modport slave (
        input  fifo_q_i, fifo_empty_i, flush_i, ready_i,
        output fifo_rdreq_o, data_o, words_o, valid_o
    );

    // Fifo / downstream / control side
    modport master (
        output fifo_q_i, fifo_empty_i, flush_i, ready_i,
        input  fifo_rdreq_o, data_o, words_o, valid_o
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops words from a showahead fifo and packs PACK of them into one output beat.
module fifo_word_packer #(
    parameter int unsigned DWIDTH = 4,
    parameter int unsigned PACK   = 4
) (
    input  logic               clk_i,
    input  logic               srst_i,
    fifo_word_packer_if.slave  bus
);
    localparam int unsigned CW = $clog2(PACK + 1);
    localparam int unsigned AW = DWIDTH * (PACK - 1);
    localparam int unsigned BW = DWIDTH * PACK;
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);
    localparam logic [CW-1:0] FULL = CW'(PACK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [BW-1:0] data_q, data_d;
    logic [CW-1:0] words_q, words_d;
    logic          valid_q, valid_d;
    logic          flush_pend_q, flush_pend_d;

    logic          out_free;
    logic          last_lane;
    logic          rdreq;
    logic          flush_req;
    logic [CW-1:0] fill;

    // Pop decision and lanes filled after this cycle's pop
    always_comb begin
        out_free  = !valid_q || bus.ready_i;
        last_lane = (cnt_q == LAST);
        rdreq     = !srst_i && !bus.fifo_empty_i && !flush_pend_q && !(last_lane && !out_free);
        flush_req = bus.flush_i || flush_pend_q;
        fill      = cnt_q + CW'(rdreq && !last_lane);
    end

    // Accumulate lanes, load full or flushed partial beats, retire consumed beats
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        data_d       = data_q;
        words_d      = words_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;

        if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end

        if (rdreq && !last_lane) begin
            acc_d[int'(cnt_q) * DWIDTH +: DWIDTH] = bus.fifo_q_i;
            cnt_d = cnt_q + CW'(1);
        end

        if (rdreq && last_lane) begin
            // Completing a full beat also satisfies any flush in this cycle
            data_d       = {bus.fifo_q_i, acc_q};
            words_d      = FULL;
            valid_d      = 1'b1;
            cnt_d        = '0;
            acc_d        = '0;
            flush_pend_d = 1'b0;
        end else if (flush_req) begin
            if (fill == '0) begin
                flush_pend_d = 1'b0;
            end else if (out_free) begin
                data_d       = BW'(acc_d);
                words_d      = fill;
                valid_d      = 1'b1;
                cnt_d        = '0;
                acc_d        = '0;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            data_q       <= '0;
            words_q      <= '0;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            data_q       <= data_d;
            words_q      <= words_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.fifo_rdreq_o = rdreq;
    assign bus.data_o       = data_q;
    assign bus.words_o      = words_q;
    assign bus.valid_o      = valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Randomized scoreboard bench for fifo_word_packer.
module tb_fifo_word_packer;
    localparam int unsigned DWIDTH = 4;
    localparam int unsigned PACK   = 4;
    localparam int unsigned CW     = $clog2(PACK + 1);
    localparam int unsigned BW     = DWIDTH * PACK;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [CW-1:0] words;
    } beat_t;

    logic clk = 1'b0;
    logic srst;

    fifo_word_packer_if #(.DWIDTH(DWIDTH), .PACK(PACK)) bus ();

    fifo_word_packer #(.DWIDTH(DWIDTH), .PACK(PACK)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [DWIDTH-1:0] fq[$];     // words sitting in the fifo
    logic [DWIDTH-1:0] lanes[$];  // words popped but not yet in a beat
    beat_t             exp_q[$];  // expected output beats, in order
    int                errors = 0;
    int                checks = 0;
    bit                was_rst = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Turns the currently collected lanes into one expected beat
    task automatic push_beat();
        beat_t b;
        b.data  = '0;
        b.words = CW'(lanes.size());
        for (int i = 0; i < lanes.size(); i++) begin
            b.data[i*DWIDTH +: DWIDTH] = lanes[i];
        end
        exp_q.push_back(b);
        lanes.delete();
    endtask

    // One clock of stimulus plus the reference model's view of that cycle
    task automatic cycle(input bit rst, input int p_push, input int p_ready,
                         input int p_flush, input bit thru);
        bit empty;
        @(negedge clk);
        empty            = (fq.size() == 0);
        srst             = rst;
        bus.fifo_empty_i = empty;
        bus.fifo_q_i     = empty ? DWIDTH'($urandom) : fq[0];
        bus.ready_i      = rst ? 1'b0 : ($urandom_range(99) < p_ready);
        bus.flush_i      = rst ? 1'b0 : ($urandom_range(99) < p_flush);
        #1;
        if (was_rst) begin
            chk("reset_valid", 64'(bus.valid_o), 64'd0);
            chk("reset_data",  64'(bus.data_o),  64'd0);
            chk("reset_words", 64'(bus.words_o), 64'd0);
        end
        if (rst) begin
            chk("rdreq_in_reset", 64'(bus.fifo_rdreq_o), 64'd0);
            lanes.delete();
            exp_q.delete();
        end else begin
            if (bus.fifo_rdreq_o) begin
                chk("no_underflow", 64'(empty), 64'd0);
                if (!empty) begin
                    lanes.push_back(fq.pop_front());
                    if (lanes.size() == PACK) push_beat();
                end
            end
            if (thru && !empty) chk("throughput_rdreq", 64'(bus.fifo_rdreq_o), 64'd1);
            if (bus.flush_i && lanes.size() > 0) push_beat();
        end
        was_rst = rst;
        if (!rst && $urandom_range(99) < p_push) fq.push_back(DWIDTH'($urandom));
    endtask

    // Monitor: compare every consumed beat against the scoreboard, check hold stability
    initial begin : monitor
        bit            prev_hold = 1'b0;
        logic [BW-1:0] prev_data = '0;
        logic [CW-1:0] prev_words = '0;
        beat_t         b;
        forever begin
            @(negedge clk);
            #2;
            if (srst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 64'(bus.valid_o), 64'd1);
                    chk("hold_data",  64'(bus.data_o),  64'(prev_data));
                    chk("hold_words", 64'(bus.words_o), 64'(prev_words));
                end
                if (bus.valid_o && bus.ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(bus.data_o), 64'hDEAD_0000_0000_0000);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data",  64'(bus.data_o),  64'(b.data));
                        chk("beat_words", 64'(bus.words_o), 64'(b.words));
                    end
                end
                prev_hold  = bus.valid_o && !bus.ready_i;
                prev_data  = bus.data_o;
                prev_words = bus.words_o;
            end
        end
    end

    initial begin : stim
        int guard;
        srst             = 1'b1;
        bus.fifo_q_i     = '0;
        bus.fifo_empty_i = 1'b1;
        bus.flush_i      = 1'b0;
        bus.ready_i      = 1'b0;
        repeat (2) cycle(1'b1, 0, 0, 0, 1'b0);

        // Stream of 1,2,3,4 -> beat 16'h4321
        fq.push_back(4'h1); fq.push_back(4'h2); fq.push_back(4'h3); fq.push_back(4'h4);
        repeat (8) cycle(1'b0, 0, 100, 0, 1'b0);

        // Flush of a two-lane partial: A,B -> 16'h00BA
        fq.push_back(4'hA); fq.push_back(4'hB);
        repeat (2) cycle(1'b0, 0, 100, 0, 1'b0);
        cycle(1'b0, 0, 100, 100, 1'b0);
        repeat (3) cycle(1'b0, 0, 100, 100, 1'b0);   // flushes of an empty accumulator

        // Mixed random traffic, then heavy backpressure with frequent flushes
        repeat (300) cycle(1'b0, 60, 70, 10, 1'b0);
        repeat (200) cycle(1'b0, 80, 20, 15, 1'b0);

        // Full rate: fifo never empty, ready always high -> one pop per cycle
        repeat (3)   cycle(1'b0, 100, 100, 0, 1'b0);
        repeat (100) cycle(1'b0, 100, 100, 0, 1'b1);

        // Stall with lanes in flight, then reset mid-operation
        repeat (7) cycle(1'b0, 100, 0, 0, 1'b0);
        cycle(1'b1, 0, 0, 0, 1'b0);
        repeat (200) cycle(1'b0, 60, 50, 10, 1'b0);

        // Drain everything, flushing the leftover partial beat
        guard = 0;
        while ((fq.size() > 0 || lanes.size() > 0 || exp_q.size() > 0) && guard < 300) begin
            cycle(1'b0, 0, 100, (fq.size() == 0) ? 100 : 0, 1'b0);
            guard++;
        end
        repeat (3) cycle(1'b0, 0, 100, 0, 1'b0);
        chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_fifo_empty",       64'(fq.size()),    64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
